// File: rtl/ping_ranger.sv
// Ultrasonic rangefinder controller: trigger, holdoff, echo measurement with timeout,
// scaled saturating result and optional free-running retrigger.
module ping_ranger #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRIG_CYC    = 2,
  parameter int unsigned HOLD_CYC    = 294,
  parameter int unsigned TIMEOUT_CYC = 65000,
  parameter int unsigned DELAY_CYC   = 80,
  parameter int unsigned RES_W       = 8,
  parameter logic [15:0] K_IN        = 16'h0479,
  parameter logic [15:0] K_CM        = 16'h0B5D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             continuous,
  input  logic             inches,
  input  logic             pulsein,
  output logic             pulseout,
  output logic             pulseen,
  output logic             busy,
  output logic             convdone,
  output logic             timeout,
  output logic [RES_W-1:0] result
);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StHold,
    StWaitEcho,
    StMeasure,
    StDelay
  } state_e;

  localparam logic [CNT_W-1:0] TrigLast  = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] ToutLast  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] One       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] tout_q, tout_d;
  logic [CNT_W-1:0] echo_q, echo_d;
  logic             ps_meta_q, ps_q;
  logic [RES_W-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;

  logic [15:0]       k;
  logic [CNT_W+15:0] prod;
  logic [CNT_W-1:0]  scaled;
  logic              sat;
  logic [RES_W-1:0]  scaled_res;

  // Q0.16 scaling; anything that does not fit in RES_W bits clamps to all-ones.
  assign k          = inches ? K_IN : K_CM;
  assign prod       = {16'b0, echo_q} * {{CNT_W{1'b0}}, k};
  assign scaled     = CNT_W'(prod >> 16);
  assign sat        = |(scaled >> RES_W);
  assign scaled_res = sat ? '1 : RES_W'(scaled);

  always_comb begin
    state_d   = state_q;
    echo_d    = echo_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = StTrig;
      end
      StTrig: begin
        if (phase_q == TrigLast) state_d = StHold;
      end
      StHold: begin
        if (phase_q == HoldLast) state_d = StWaitEcho;
      end
      StWaitEcho: begin
        if (tout_q == ToutLast) begin
          state_d   = StDelay;
          result_d  = '1;
          timeout_d = 1'b1;
        end else if (ps_q) begin
          state_d = StMeasure;
          echo_d  = One;
        end
      end
      StMeasure: begin
        // Timeout takes priority over an echo falling edge in the same cycle.
        if (tout_q == ToutLast) begin
          state_d   = StDelay;
          result_d  = '1;
          timeout_d = 1'b1;
        end else if (!ps_q) begin
          state_d   = StDelay;
          result_d  = scaled_res;
          timeout_d = 1'b0;
        end else if (echo_q != '1) begin
          echo_d = echo_q + One;
        end
      end
      StDelay: begin
        if (phase_q == DelayLast) state_d = continuous ? StTrig : StIdle;
      end
      default: state_d = StIdle;
    endcase

    phase_d = (state_d != state_q) ? '0 : phase_q + One;
    tout_d  = (state_q == StWaitEcho || state_q == StMeasure) ? tout_q + One : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      tout_q    <= '0;
      echo_q    <= '0;
      ps_meta_q <= 1'b0;
      ps_q      <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tout_q    <= tout_d;
      echo_q    <= echo_d;
      ps_meta_q <= pulsein;
      ps_q      <= ps_meta_q;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  assign pulseout = (state_q == StTrig);
  assign pulseen  = (state_q == StIdle) || (state_q == StTrig) || (state_q == StHold);
  assign busy     = (state_q != StIdle);
  assign convdone = (state_q == StDelay) && (phase_q == DelayLast);
  assign timeout  = timeout_q;
  assign result   = result_q;

endmodule

// File: tb/tb_ping_ranger.sv
// Self-checking bench for ping_ranger: table vectors, continuous/reset sequences and
// randomized echoes checked against a cycle-timeline model.
module tb_ping_ranger;

  localparam int TRIG = 2;
  localparam int HOLD = 294;
  localparam int DLY  = 80;
  localparam int TOUT = 10010;
  localparam int W    = TRIG + HOLD;  // first WAIT_ECHO cycle, counted from the go edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       continuous = 1'b0;
  logic       inches = 1'b0;
  logic       pulsein = 1'b0;
  logic       pulseout, pulseen, busy, convdone, timeout;
  logic [7:0] result;

  ping_ranger #(
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .continuous(continuous),
    .inches    (inches),
    .pulsein   (pulsein),
    .pulseout  (pulseout),
    .pulseen   (pulseen),
    .busy      (busy),
    .convdone  (convdone),
    .timeout   (timeout),
    .result    (result)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] prev_res = 8'd0;
  logic       prev_to = 1'b0;

  typedef struct {
    int   s;
    int   len;
    bit   inch;
    int   exp_res;
    bit   exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // s = WAIT_ECHO cycle of the first synchronised high, len = echo length (0 = none).
  function automatic bit model_to(input int s, input int len);
    return (len == 0) || (s + len >= TOUT - 1);
  endfunction

  function automatic int model_res(input int s, input int len, input bit inch);
    longint p;
    if (model_to(s, len)) return 255;
    p = longint'(len) * (inch ? 1145 : 2909);
    p = p / 65536;
    return (p > 255) ? 255 : int'(p);
  endfunction

  task automatic run_conv(input int s, input int len, input bit inch, input bit cont,
                          input bit from_go, input bit rand_go, input int exp_res,
                          input bit exp_to, input string tag);
    int d, last;
    int bad_po = 0, bad_en = 0, bad_busy = 0, bad_cd = 0, bad_res = 0;
    d    = W + (exp_to ? TOUT - 1 : s + len) + 1;
    last = d + DLY - 1;
    inches     = inch;
    continuous = cont;
    if (from_go) begin
      go = 1'b1;
      step();
    end
    for (int c = 0; c <= last; c++) begin
      if (pulseout !== (c < TRIG)) bad_po++;
      if (pulseen !== (c < W)) bad_en++;
      if (busy !== 1'b1) bad_busy++;
      if (convdone !== (c == last)) bad_cd++;
      if (c < d) begin
        if (result !== prev_res || timeout !== prev_to) bad_res++;
      end else begin
        if (result !== 8'(exp_res) || timeout !== exp_to) bad_res++;
      end
      pulsein = (len > 0) && (c >= W + s - 2) && (c < W + s + len - 2);
      go      = rand_go ? ($urandom_range(1, 0) != 0) : 1'b0;
      step();
    end
    go      = 1'b0;
    pulsein = 1'b0;
    check($sformatf("%s pulseout_bad_cycles", tag), bad_po, 0);
    check($sformatf("%s pulseen_bad_cycles", tag), bad_en, 0);
    check($sformatf("%s busy_bad_cycles", tag), bad_busy, 0);
    check($sformatf("%s convdone_bad_cycles", tag), bad_cd, 0);
    check($sformatf("%s result_timeline_bad_cycles", tag), bad_res, 0);
    check($sformatf("%s result", tag), result, exp_res);
    check($sformatf("%s timeout", tag), timeout, exp_to);
    check($sformatf("%s after_busy", tag), busy, cont);
    check($sformatf("%s after_pulseout", tag), pulseout, cont);
    check($sformatf("%s after_pulseen", tag), pulseen, 1);
    prev_res = 8'(exp_res);
    prev_to  = exp_to;
  endtask

  initial begin
    vec_t vecs[$];
    int   bad;
    int   s, len;
    bit   inch;

    vecs.push_back('{s: 3, len: 10000, inch: 1'b1, exp_res: 174, exp_to: 1'b0});
    vecs.push_back('{s: 0, len: 10000, inch: 1'b0, exp_res: 255, exp_to: 1'b0});
    vecs.push_back('{s: 5, len: 1000,  inch: 1'b0, exp_res: 44,  exp_to: 1'b0});
    vecs.push_back('{s: 0, len: 0,     inch: 1'b1, exp_res: 255, exp_to: 1'b1});
    vecs.push_back('{s: 1, len: 1000,  inch: 1'b1, exp_res: 17,  exp_to: 1'b0});
    vecs.push_back('{s: 2, len: 1,     inch: 1'b0, exp_res: 0,   exp_to: 1'b0});
    vecs.push_back('{s: 4, len: 58,    inch: 1'b1, exp_res: 1,   exp_to: 1'b0});
    vecs.push_back('{s: 0, len: 57,    inch: 1'b1, exp_res: 0,   exp_to: 1'b0});
    vecs.push_back('{s: 9, len: 10000, inch: 1'b1, exp_res: 255, exp_to: 1'b1});
    vecs.push_back('{s: 8, len: 10000, inch: 1'b1, exp_res: 174, exp_to: 1'b0});
    vecs.push_back('{s: 7, len: 300,   inch: 1'b0, exp_res: 13,  exp_to: 1'b0});

    // Reset and idle.
    repeat (3) step();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset pulseen", pulseen, 1);
    check("reset pulseout", pulseout, 0);
    check("reset result", result, 0);
    check("reset timeout", timeout, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (pulseout !== 1'b0 || pulseen !== 1'b1 || busy !== 1'b0 || convdone !== 1'b0 ||
          result !== 8'd0) bad++;
      step();
    end
    check("idle_bad_cycles", bad, 0);

    foreach (vecs[i]) begin
      run_conv(vecs[i].s, vecs[i].len, vecs[i].inch, 1'b0, 1'b1, 1'b0, vecs[i].exp_res,
               vecs[i].exp_to, $sformatf("vec%0d", i));
    end

    // Continuous mode: three back-to-back conversions, continuous dropped on the last.
    run_conv(2, 100, 1'b1, 1'b1, 1'b1, 1'b0, model_res(2, 100, 1'b1), model_to(2, 100),
             "cont0");
    run_conv(3, 200, 1'b0, 1'b1, 1'b0, 1'b1, model_res(3, 200, 1'b0), model_to(3, 200),
             "cont1");
    run_conv(1, 150, 1'b1, 1'b0, 1'b0, 1'b0, model_res(1, 150, 1'b1), model_to(1, 150),
             "cont2");

    for (int r = 0; r < 8; r++) begin
      s    = int'($urandom_range(20, 0));
      len  = int'($urandom_range(600, 1));
      inch = ($urandom_range(1, 0) != 0);
      run_conv(s, len, inch, 1'b0, 1'b1, 1'b1, model_res(s, len, inch), model_to(s, len),
               $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a measurement.
    inches     = 1'b1;
    continuous = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int c = 0; c < W + 55; c++) begin
      pulsein = (c >= W + 3);
      step();
    end
    check("premid busy", busy, 1);
    check("premid pulseen", pulseen, 0);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    pulsein = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset pulseen", pulseen, 1);
    check("midreset result", result, 0);
    check("midreset timeout", timeout, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (convdone !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    check("midreset_quiet_bad_cycles", bad, 0);
    prev_res = 8'd0;
    prev_to  = 1'b0;
    run_conv(0, 500, 1'b0, 1'b0, 1'b1, 1'b0, model_res(0, 500, 1'b0), model_to(0, 500),
             "postreset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ping_ranger.md
Name: ping_ranger

Overview:
Parametrised ultrasonic rangefinder controller that replaces the fixed-timing single-shot ping block. It drives the shared trigger/echo line, measures echo width, and scales the width to inches or centimetres with a RES_W-bit saturating result. It adds three things the earlier block lacks: an echo timeout, a free-running continuous mode, and an input synchroniser. It sits between the sensor pin driver and the display/result register logic.

Parameters:
CNT_W, 16, width of all internal cycle counters
TRIG_CYC, 2, trigger pulse length in clk cycles (>=1)
HOLD_CYC, 294, holdoff after trigger before echo is watched (>=1)
TIMEOUT_CYC, 65000, max cycles in WAIT_ECHO+MEASURE combined (<=2^CNT_W-1)
DELAY_CYC, 80, post-measurement quiet time (>=2)
RES_W, 8, result width (1..16)
K_IN, 16'h0479, inch scale factor, Q0.16
K_CM, 16'h0B5D, centimetre scale factor, Q0.16

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  start request; sampled only in IDLE
continuous  in  1  1 = retrigger automatically after DELAY
inches  in  1  1 = inch scaling, 0 = cm; sampled at result load
pulsein  in  1  asynchronous echo input from the sensor line
pulseout  out  1  trigger drive level
pulseen  out  1  line output enable (1 = block drives line)
busy  out  1  high in every state except IDLE
convdone  out  1  one-cycle strobe at conversion end
timeout  out  1  last conversion timed out; updated with result
result  out  RES_W  scaled distance

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high. All registers update on the rising edge of clk.
- Synchroniser: pulsein passes through 2 flops to give ps. All echo decisions use ps, which adds 2 cycles of latency.
- States: IDLE, TRIG, HOLD, WAIT_ECHO, MEASURE, DELAY. A single phase counter (CNT_W bits) clears on every state change.
- IDLE: go=1 -> TRIG on the next cycle. go is ignored in all other states.
- TRIG: pulseout=1. Stay exactly TRIG_CYC cycles, then -> HOLD.
- HOLD: stay exactly HOLD_CYC cycles, then -> WAIT_ECHO.
- pulseen=1 in IDLE, TRIG and HOLD; 0 otherwise. pulseout=1 only in TRIG.
- WAIT_ECHO: ps=1 -> MEASURE with echo_cnt loaded to 1.
- MEASURE: each cycle with ps=1, echo_cnt increments, saturating at 2^CNT_W-1. ps=0 -> DELAY, load result.
- Timeout: a tout counter runs in WAIT_ECHO and MEASURE. When it reaches TIMEOUT_CYC -> DELAY, the result loads all-ones and timeout loads 1. If timeout and ps=0 occur in the same cycle, timeout wins.
- Result arithmetic: prod = echo_cnt * K (CNT_W+16 bits, unsigned), with K = inches ? K_IN : K_CM. scaled = prod >> 16. If scaled >= 2^RES_W, result = all-ones; otherwise result = scaled[RES_W-1:0]. A normal load clears timeout.
- result and timeout are registered on the DELAY-entry edge and hold until the next load or reset.
- DELAY: stay DELAY_CYC cycles. convdone=1 on the last DELAY cycle only. Next state is TRIG if continuous=1 (sampled on that cycle), otherwise IDLE.
- Latency: go high at edge N gives pulseout high from edge N+1 through N+TRIG_CYC.
- Reset values: state IDLE, pulseout 0, pulseen 1, busy 0, convdone 0, timeout 0, result 0, all counters 0, synchroniser 0.
- Reset mid-operation: the block is in IDLE after the reset edge, the line is released to pulseen=1, and no convdone is issued.
- Clearing continuous mid-cycle lets the current conversion finish, then the block returns to IDLE.

Test Plan:
- Reset, then idle with go=0: pulseen=1, busy=0, result=0, no pulseout for 100 cycles.
- Defaults, go=1 for 1 cycle, inches=1, echo high for exactly 10000 cycles: pulseout high 2 cycles, HOLD lasts 294 cycles, result=174 (10000*1145>>16), timeout=0, convdone one cycle at DELAY end, then IDLE.
- Same echo with inches=0: 10000*2909>>16 = 443 -> result=255 (saturated); with echo of 1000 cycles -> result=44.
- TIMEOUT_CYC=1000, no echo: DELAY entered 1000 cycles after WAIT_ECHO entry, result=255, timeout=1, convdone pulses; the next good echo clears timeout.
- continuous=1, go once: TRIG restarts on the cycle after each convdone for 3 conversions; dropping continuous gives IDLE after the current convdone.
- reset asserted mid-MEASURE: next cycle is IDLE, result=0, no convdone; go afterwards produces a normal conversion.
